// File: rtl/pipe_stage_ctrl.sv
// Pipeline-register chain with priority-encoded stall point, flush handshake,
// retire register and saturating stall/bubble/retire performance counters.
module pipe_stage_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter logic [WIDTH-1:0] BUBBLE_DATA = '0,
  parameter int unsigned CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [(STAGES+1)*WIDTH-1:0]   stage_in,
  input  logic [STAGES:0]               stage_in_valid,
  input  logic [STAGES-1:0]             stall_req,
  input  logic [STAGES-1:0]             flush_req,
  output logic                          flush_ack,
  output logic [STAGES*WIDTH-1:0]       stage_q,
  output logic [STAGES-1:0]             stage_q_valid,
  output logic [WIDTH-1:0]              retire_data,
  output logic                          retire_valid,
  output logic [CNT_W-1:0]              stall_cycles,
  output logic [CNT_W-1:0]              bubble_count,
  output logic [CNT_W-1:0]              retire_count
);

  // One extra bit so h+1 and f+1 never overflow
  localparam int unsigned IDX_W = $clog2(STAGES) + 1;
  localparam int unsigned SUM_W = CNT_W + IDX_W + 1;

  logic [STAGES-1:0][WIDTH-1:0] q_r, q_nxt;
  logic [STAGES-1:0]            v_r, v_nxt;
  logic [WIDTH-1:0]             ret_r, ret_nxt;
  logic                         ret_v_r, ret_v_nxt;
  logic                         ack_nxt;
  logic [CNT_W-1:0]             stall_cnt_r, stall_cnt_nxt;
  logic [CNT_W-1:0]             bubble_cnt_r, bubble_cnt_nxt;
  logic [CNT_W-1:0]             retire_cnt_r, retire_cnt_nxt;
  logic                         any_stall, do_flush;
  logic [IDX_W-1:0]             stall_idx, flush_idx, bubble_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [IDX_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(inc);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return CNT_W'(s);
  endfunction

  // Highest-index request wins for both stall and flush
  always_comb begin
    stall_idx = '0;
    flush_idx = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stall_req[k]) stall_idx = IDX_W'(k);
      if (flush_req[k]) flush_idx = IDX_W'(k);
    end
    any_stall = |stall_req;
    do_flush  = (|flush_req) & ~any_stall;
  end

  // Register update policy: stall holds/bubbles, otherwise flush, otherwise advance
  always_comb begin
    q_nxt      = '0;
    v_nxt      = '0;
    ret_nxt    = stage_in[STAGES*WIDTH +: WIDTH];
    ret_v_nxt  = stage_in_valid[STAGES];
    bubble_inc = '0;
    for (int i = 0; i < STAGES; i++) begin
      q_nxt[i] = stage_in[i*WIDTH +: WIDTH];
      v_nxt[i] = stage_in_valid[i];
      if (any_stall) begin
        if (IDX_W'(i) <= stall_idx) begin
          q_nxt[i] = q_r[i];
          v_nxt[i] = v_r[i];
        end else if (IDX_W'(i) == stall_idx + IDX_W'(1)) begin
          q_nxt[i] = BUBBLE_DATA;
          v_nxt[i] = 1'b0;
        end
      end else if (do_flush && (IDX_W'(i) <= flush_idx)) begin
        q_nxt[i] = BUBBLE_DATA;
        v_nxt[i] = 1'b0;
      end
    end
    if (any_stall && (stall_idx == IDX_W'(STAGES - 1))) begin
      ret_nxt   = BUBBLE_DATA;
      ret_v_nxt = 1'b0;
    end
    // A stall always injects one bubble (into r[h+1] or the retire register)
    if (any_stall)     bubble_inc = IDX_W'(1);
    else if (do_flush) bubble_inc = flush_idx + IDX_W'(1);
    ack_nxt        = do_flush;
    stall_cnt_nxt  = sat_add(stall_cnt_r, IDX_W'(any_stall));
    bubble_cnt_nxt = sat_add(bubble_cnt_r, bubble_inc);
    retire_cnt_nxt = sat_add(retire_cnt_r, IDX_W'(ret_v_nxt));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_r          <= {STAGES{RESET_DATA}};
      v_r          <= '0;
      ret_r        <= RESET_DATA;
      ret_v_r      <= 1'b0;
      flush_ack    <= 1'b0;
      stall_cnt_r  <= '0;
      bubble_cnt_r <= '0;
      retire_cnt_r <= '0;
    end else begin
      q_r          <= q_nxt;
      v_r          <= v_nxt;
      ret_r        <= ret_nxt;
      ret_v_r      <= ret_v_nxt;
      flush_ack    <= ack_nxt;
      stall_cnt_r  <= stall_cnt_nxt;
      bubble_cnt_r <= bubble_cnt_nxt;
      retire_cnt_r <= retire_cnt_nxt;
    end
  end

  assign stage_q       = q_r;
  assign stage_q_valid = v_r;
  assign retire_data   = ret_r;
  assign retire_valid  = ret_v_r;
  assign stall_cycles  = stall_cnt_r;
  assign bubble_count  = bubble_cnt_r;
  assign retire_count  = retire_cnt_r;

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Parametrised pipeline-register chain and stall/flush controller for the MIPS core.
- Generalises the hard-wired D/E/M/W register update logic in the core top to any number of stages, with a priority-encoded stall point, a flush request/ack handshake, per-register valid bits, a retire (debug) register, and stall/bubble/retire performance counters.
- Per-stage combinational logic (decode, execute, memory, writeback) stays outside; this block owns only the registers and the update policy.

Parameters:
- STAGES, 4: number of pipeline registers r[0..STAGES-1] (r[0] = decode register); legal range 2..16.
- WIDTH, 64: payload bits per register (packed stage content).
- RESET_DATA, 0: payload loaded into every r[i] and retire register on reset.
- BUBBLE_DATA, 0: payload loaded into a register when a bubble is inserted.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- stage_in  in  (STAGES+1)*WIDTH  entry i (i<STAGES) is the next value for r[i]; entry 0 = fetch output; entry STAGES feeds the retire register
- stage_in_valid  in  STAGES+1  valid bit accompanying each stage_in entry
- stall_req  in  STAGES  stall_req[k]=1: the stage consuming r[k] cannot complete this cycle
- flush_req  in  STAGES  flush_req[k]=1: discard r[0..k]; level, held until flush_ack
- flush_ack  out  1  one-cycle pulse; the flush was applied on this edge
- stage_q  out  STAGES*WIDTH  current contents of r[0..STAGES-1]
- stage_q_valid  out  STAGES  valid bits of r[0..STAGES-1]
- retire_data  out  WIDTH  registered copy of stage_in[STAGES]
- retire_valid  out  1  valid bit of the retire register
- stall_cycles  out  CNT_W  number of cycles with any stall_req set
- bubble_count  out  CNT_W  number of bubbles inserted
- retire_count  out  CNT_W  number of cycles with retire_valid loaded as 1

Behaviour:
Reset (resetn=0 at a clk edge):
- All r[i] and the retire register load RESET_DATA with valid=0.
- All counters clear to 0; flush_ack=0.
- Reset overrides every request, including a stall or flush in progress.

Stall point:
- h = highest index k with stall_req[k]=1 (priority encoder; highest index wins).
- With a stall point h:
  - r[0..h] hold their own value and valid bit.
  - r[h+1] loads BUBBLE_DATA with valid=0, unless h = STAGES-1.
  - r[j] for j > h+1 loads stage_in[j] / stage_in_valid[j].
  - The retire register loads BUBBLE_DATA, valid=0, when h = STAGES-1; otherwise it loads stage_in[STAGES].
- With no stall: every r[i] and the retire register load their stage_in entry.
- This is the same behaviour as the existing core:
  - memory wait = stall at the M index;
  - fetch wait = stall at the E index;
  - load-use hazard = stall at the D index.

Flush:
- f = highest index with flush_req set.
- Applied only in a cycle with no stall_req set:
  - r[0..f] load BUBBLE_DATA with valid=0.
  - Registers above f advance normally.
  - flush_ack=1 for exactly that cycle (registered, visible the cycle after the edge).
- During any stall the flush is deferred; the requester keeps flush_req high.
- A flush and a no-stall advance never both apply to the same register; flush wins for r[0..f].
- flush_ack deasserts the following cycle even if flush_req is still high. A still-high flush_req on the next cycle is a new request.

Counters (all saturating at all-ones, no wrap):
- stall_cycles increments in every non-reset cycle with |stall_req.
- bubble_count increments by 1 per cycle in which a stall bubble is inserted.
  - A flush counts as f+1 bubbles.
  - Increment width is limited to CNT_W.
- retire_count increments when the retire register loads valid=1.

Latency and outputs:
- All outputs are registered; stage_in reaches stage_q one clk after being sampled.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: resetn=0 for 2 cycles with all stall_req/flush_req high -> all stage_q=RESET_DATA, all valid=0, counters=0, flush_ack=0.
- Free flow, STAGES=4: stage_in[i]=0x10+i for 4 cycles, all valid -> stage_q[i]=0x10+i each cycle; retire_data=0x14; retire_count=4.
- Single stall: stall_req=4'b0001 for 1 cycle -> r[0] unchanged, r[1]=BUBBLE/valid=0, r[2], r[3], retire advance; stall_cycles=1, bubble_count=1.
- Nested stalls: stall_req=4'b1001 for 3 cycles -> all of r[0..3] hold; retire valid=0 each cycle; stall_cycles=3; retire_count unchanged.
- Flush vs stall: flush_req[1]=1 with stall_req[2]=1 for 2 cycles, then stall released:
  - flush_ack stays 0 during the stall.
  - On the first free edge, r[0], r[1] become bubbles and r[2], r[3] advance.
  - flush_ack pulses 1 cycle; bubble_count +2.
- Saturation, CNT_W=4: stall held 20 cycles -> stall_cycles stops at 15; then reset mid-stall -> counters=0 and regs=RESET_DATA on that edge.
